mdu_e: RTL and testbench
========================

# mdu_e

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It runs MULT/MULTU/DIV/DIVU, and optionally MADD/MADDU/MSUB/MSUBU, as multi-cycle operations, holds the HI/LO registers and handles MTHI/MTLO. It provides MFHI/MFLO read data to the E-stage result mux, which feeds the E/M pipeline register. Its busy flag lets the hazard unit stall multiply/divide-class instructions in D.

## Interface
- MUL_CYCLES, 5: busy cycles for multiply-class ops
- DIV_CYCLES, 10: busy cycles for divide-class ops
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  an MDU arithmetic instruction is in E this cycle (sampled once)
- op  in  3  operation code (encodings in shared defs)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- hilo_we  in  1  MTHI/MTLO in E this cycle
- hilo_sel  in  1  1 = HI, 0 = LO; selects the target for hilo_we and the source for md_out
- md_out  out  32  combinational: HI if hilo_sel, else LO (MFHI/MFLO data)
- HI  out  32  registered HI
- LO  out  32  registered LO
- busy  out  1  registered; operation in flight

## Operation
- State: IDLE, RUN. Down-counter cnt of 4 bits minimum. Pending result regs P_HI, P_LO.
- IDLE and start:
  - Compute the result from A/B at that edge and store it in P_HI/P_LO.
  - Load cnt with MUL_CYCLES or DIV_CYCLES, go to RUN, set busy = 1.
- RUN: decrement cnt each cycle. When cnt reaches 1, commit P_HI/P_LO to HI/LO, clear busy and return to IDLE at the same edge.
- MULT/MULTU: {HI,LO} = signed/unsigned 64-bit product.
- DIV/DIVU: LO = quotient, HI = remainder, signed or unsigned.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero: LO = 0xFFFFFFFF and HI = A, for both signed and unsigned. The unit still stays busy for DIV_CYCLES.
- hilo_we in IDLE without start: the selected register takes A at the edge; no busy.
- Simultaneous start and hilo_we: start wins; the write is dropped.
- start or hilo_we while busy: ignored, state unchanged. The hazard unit is responsible for never issuing these.
- Invalid op code with start: treated as a no-op; no busy, HI/LO unchanged.
- md_out reflects the committed HI/LO only, never the pending values.

## Timing
- Reset values: HI = 0, LO = 0, busy = 0, cnt = 0, state IDLE, P_HI/P_LO = 0. md_out = 0 after reset.
- Reset mid-operation aborts it: nothing is committed and busy = 0 on the next cycle.
- start sampled at edge t: busy = 1 in cycles t+1 .. t+N, where N = MUL_CYCLES or DIV_CYCLES.
- New HI/LO are visible from cycle t+N+1, the same cycle busy = 0.
- MTHI/MTLO written at edge t are visible on md_out and HI/LO in cycle t+1.
- Hazard contract, implemented outside this block: stall an MDU-class instruction in D while (busy | start).
- A start may be issued in the first cycle busy = 0; back-to-back operations have no dead cycle.

## Configuration
- MDU_MADD_EN defined:
  - MADD/MADDU: {HI,LO} += signed/unsigned product.
  - MSUB/MSUBU: {HI,LO} -= signed/unsigned product.
  - Accumulation is modulo 2^64 and uses the HI/LO value committed at the start edge. Latency is MUL_CYCLES.
- MDU_MADD_EN undefined: the four accumulate codes are treated as invalid (no-op, no busy).

## Structure
- Shared defines header (mdu_defs.vh), used by the decoder and this block:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7
  - state encodings
- Sub-module mdu_arith: purely combinational.
  - Inputs: op, A, B, current HI/LO. Outputs: res_hi, res_lo, valid_op.
  - Contains the divide-by-zero rule and all MDU_MADD_EN logic.
- mdu_e holds the FSM, counter, pending registers, HI/LO and the md_out mux.

## Test plan
- MULT, A=0xFFFFFFFE (-2), B=3 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with MULTU → HI=0x2, LO=0xFFFFFFFA.
- DIV, A=-7, B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=0 → LO=0xFFFFFFFF, HI=7.
- MTHI A=0x12345678, then MFHI the next cycle → md_out=0x12345678. start with hilo_we in the same cycle → the write is dropped.
- Reset asserted in cycle 3 of a DIV → busy=0 and HI=LO=0 the next cycle; the result is never committed.
- DIV started; in busy cycle 4, drive start=1 (MULT) and hilo_we=1 → both ignored; the DIV result commits after 10 cycles. A MULT issued the cycle busy drops completes 5 cycles later.
- MDU_MADD_EN: with HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0. With the macro undefined, the same op leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/mdu_e_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, FSM state encodings and small arithmetic helpers.
package mdu_e_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement negation of a word.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Divide-class operations take the longer latency.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_e_arith.sv
// Combinational result generator for the multiply/divide unit.
// Produces the full {HI,LO} result for a given op and operands, including
// the divide-by-zero rule. Accumulate ops (MADD/MADDU/MSUB/MSUBU) are only
// recognised when the MDU_MADD_EN macro is defined; otherwise they report
// valid_op = 0.
module mdu_e_arith
  import mdu_e_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] hi_cur,
  input  logic [DATA_W-1:0] lo_cur,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              valid_op
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [DATA_W-1:0]   mag_a;
  logic        [DATA_W-1:0]   mag_b;
  logic        [DATA_W-1:0]   div_b_s;
  logic        [DATA_W-1:0]   div_b_u;
  logic        [DATA_W-1:0]   q_mag;
  logic        [DATA_W-1:0]   r_mag;
  logic        [DATA_W-1:0]   q_s;
  logic        [DATA_W-1:0]   r_s;
  logic        [DATA_W-1:0]   q_u;
  logic        [DATA_W-1:0]   r_u;
  logic                       b_zero;

  // Products: sign-extended operands give the exact signed 64-bit product
  // modulo 2^64, which is all HI/LO can hold.
  always_comb begin
    prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  end

  // Signed division via magnitudes: quotient sign from operand signs,
  // remainder sign from the dividend. The zero divisor is replaced by 1
  // so the divider never sees /0; the result is overridden below anyway.
  always_comb begin
    b_zero  = (b == '0);
    mag_a   = abs_w(a);
    mag_b   = abs_w(b);
    div_b_s = b_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : mag_b;
    div_b_u = b_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
    q_mag   = mag_a / div_b_s;
    r_mag   = mag_a % div_b_s;
    q_s     = (a[DATA_W-1] ^ b[DATA_W-1]) ? neg_w(q_mag) : q_mag;
    r_s     = a[DATA_W-1] ? neg_w(r_mag) : r_mag;
    q_u     = a / div_b_u;
    r_u     = a % div_b_u;
  end

`ifdef MDU_MADD_EN
  logic [2*DATA_W-1:0] acc_cur;
  logic [2*DATA_W-1:0] acc_res;

  // Accumulate ops work on the committed HI/LO, wrapping modulo 2^64.
  always_comb begin
    acc_cur = {hi_cur, lo_cur};
    case (op)
      OP_MADD:  acc_res = acc_cur + prod_s;
      OP_MADDU: acc_res = acc_cur + prod_u;
      OP_MSUB:  acc_res = acc_cur - prod_s;
      OP_MSUBU: acc_res = acc_cur - prod_u;
      default:  acc_res = acc_cur;
    endcase
  end
`else
  logic unused_acc;
  assign unused_acc = ^{hi_cur, lo_cur};
`endif

  // Result select per op code; anything unrecognised is flagged invalid.
  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    valid_op = 1'b0;
    case (op)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        valid_op = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        valid_op = 1'b1;
      end
      OP_DIV: begin
        res_lo   = b_zero ? '1 : q_s;
        res_hi   = b_zero ? a  : r_s;
        valid_op = 1'b1;
      end
      OP_DIVU: begin
        res_lo   = b_zero ? '1 : q_u;
        res_hi   = b_zero ? a  : r_u;
        valid_op = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = acc_res;
        valid_op = 1'b1;
      end
`endif
      default: begin
        valid_op = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit for the five-stage MIPS pipeline.
// Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle ops, holds HI/LO,
// handles MTHI/MTLO and supplies MFHI/MFLO data on md_out.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// The result is computed at the start edge into pending registers and only
// committed to HI/LO when the latency counter expires, so md_out never
// shows an in-flight result.
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              hilo_we,
  input  logic              hilo_sel,
  output logic [DATA_W-1:0] md_out,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  mdu_state_e          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                busy_n;
  logic [DATA_W-1:0]   p_hi, p_hi_n;
  logic [DATA_W-1:0]   p_lo, p_lo_n;
  logic [DATA_W-1:0]   hi_q, hi_n;
  logic [DATA_W-1:0]   lo_q, lo_n;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  logic                valid_op;

  mdu_e_arith u_arith (
    .op       (op),
    .a        (A),
    .b        (B),
    .hi_cur   (hi_q),
    .lo_cur   (lo_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .valid_op (valid_op)
  );

  // Next-state logic: launch, count down, commit, or take an MTHI/MTLO write.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          // start takes priority over a same-cycle hilo_we; an invalid op
          // is simply a no-op.
          if (valid_op) begin
            p_hi_n  = res_hi;
            p_lo_n  = res_lo;
            cnt_n   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_n = S_RUN;
            busy_n  = 1'b1;
          end
        end else if (hilo_we) begin
          if (hilo_sel) hi_n = A;
          else          lo_n = A;
        end
      end
      S_RUN: begin
        // start/hilo_we are deliberately ignored while running.
        if (cnt == CNT_W'(1)) begin
          hi_n    = p_hi;
          lo_n    = p_lo;
          cnt_n   = '0;
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, pending and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      p_hi  <= '0;
      p_lo  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign HI     = hi_q;
  assign LO     = lo_q;
  assign md_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Directed self-checking bench for mdu_e (default latencies 5/10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] md_out;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  int checks = 0;
  int passes = 0;

  mdu_e #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .md_out   (md_out),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Issue one start pulse; entered and left on a falling edge.
  task automatic do_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles from the current cycle on, bounded at 100.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // One MTHI/MTLO write.
  task automatic do_mt(input logic sel, input logic [31:0] a);
    hilo_we = 1'b1; hilo_sel = sel; A = a;
    @(negedge clk);
    hilo_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hilo_sel = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passes++;
    checks++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", HI); else passes++;
    checks++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", LO); else passes++;
    checks++; if (md_out !== 32'h0) $display("FAIL reset_md_out: got %h expected 00000000", md_out); else passes++;
  endtask

  task automatic test_mult();
    int n;
    do_start(3'd0, 32'hFFFFFFFE, 32'd3);
    checks++; if (busy !== 1'b1) $display("FAIL mult_busy_t1: got %0b expected 1", busy); else passes++;
    checks++; if (LO !== 32'h0) $display("FAIL mult_pending_hidden: got %h expected 00000000", LO); else passes++;
    wait_idle(n);
    checks++; if (n !== 5) $display("FAIL mult_latency: got %0d expected 5", n); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", HI); else passes++;
    checks++; if (LO !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h expected fffffffa", LO); else passes++;
    do_start(3'd1, 32'hFFFFFFFE, 32'd3);
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL multu_pending_hidden: got %h expected ffffffff", HI); else passes++;
    wait_idle(n);
    checks++; if (n !== 5) $display("FAIL multu_latency: got %0d expected 5", n); else passes++;
    checks++; if (HI !== 32'h2) $display("FAIL multu_hi: got %h expected 00000002", HI); else passes++;
    checks++; if (LO !== 32'hFFFFFFFA) $display("FAIL multu_lo: got %h expected fffffffa", LO); else passes++;
  endtask

  task automatic test_div();
    int n;
    do_start(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) $display("FAIL div_latency: got %0d expected 10", n); else passes++;
    checks++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h expected fffffffd", LO); else passes++;
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h expected ffffffff", HI); else passes++;
    do_start(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    checks++; if (n !== 10) $display("FAIL divu_zero_latency: got %0d expected 10", n); else passes++;
    checks++; if (LO !== 32'hFFFFFFFF) $display("FAIL divu_zero_lo: got %h expected ffffffff", LO); else passes++;
    checks++; if (HI !== 32'h7) $display("FAIL divu_zero_hi: got %h expected 00000007", HI); else passes++;
    do_start(3'd2, 32'hFFFFFFF6, 32'd0);
    wait_idle(n);
    checks++; if (LO !== 32'hFFFFFFFF) $display("FAIL div_zero_lo: got %h expected ffffffff", LO); else passes++;
    checks++; if (HI !== 32'hFFFFFFF6) $display("FAIL div_zero_hi: got %h expected fffffff6", HI); else passes++;
    do_start(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (LO !== 32'h80000000) $display("FAIL div_ovf_lo: got %h expected 80000000", LO); else passes++;
    checks++; if (HI !== 32'h0) $display("FAIL div_ovf_hi: got %h expected 00000000", HI); else passes++;
    do_start(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    hilo_sel = 1'b0;
    #1;
    checks++; if (md_out !== 32'hFFFFFFFD) $display("FAIL div_neg_divisor_lo: got %h expected fffffffd", md_out); else passes++;
    hilo_sel = 1'b1;
    #1;
    checks++; if (md_out !== 32'h1) $display("FAIL div_neg_divisor_hi: got %h expected 00000001", md_out); else passes++;
    do_start(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (LO !== 32'h7FFFFFFC) $display("FAIL divu_lo: got %h expected 7ffffffc", LO); else passes++;
    checks++; if (HI !== 32'h1) $display("FAIL divu_hi: got %h expected 00000001", HI); else passes++;
  endtask

  task automatic test_hilo();
    int n;
    do_mt(1'b1, 32'h12345678);
    hilo_sel = 1'b1;
    #1;
    checks++; if (md_out !== 32'h12345678) $display("FAIL mfhi: got %h expected 12345678", md_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %0b expected 0", busy); else passes++;
    checks++; if (LO !== 32'h7FFFFFFC) $display("FAIL mthi_lo_kept: got %h expected 7ffffffc", LO); else passes++;
    do_mt(1'b0, 32'hCAFEBABE);
    hilo_sel = 1'b0;
    #1;
    checks++; if (md_out !== 32'hCAFEBABE) $display("FAIL mflo: got %h expected cafebabe", md_out); else passes++;
    checks++; if (HI !== 32'h12345678) $display("FAIL mtlo_hi_kept: got %h expected 12345678", HI); else passes++;
    @(negedge clk);
    // start and hilo_we together: the MTHI of DEADBEEF must be dropped.
    hilo_we = 1'b1; hilo_sel = 1'b1;
    do_start(3'd0, 32'hDEADBEEF, 32'd1);
    hilo_we = 1'b0;
    checks++; if (HI !== 32'h12345678) $display("FAIL start_wins_hi_t1: got %h expected 12345678", HI); else passes++;
    wait_idle(n);
    checks++; if (HI !== 32'hFFFFFFFF) $display("FAIL start_wins_hi: got %h expected ffffffff", HI); else passes++;
    checks++; if (LO !== 32'hDEADBEEF) $display("FAIL start_wins_lo: got %h expected deadbeef", LO); else passes++;
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(3'd3, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 4) begin
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd5;
        hilo_we = 1'b1; hilo_sel = 1'b0;
      end
      if (n == 5) begin
        start = 1'b0; hilo_we = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (n !== 10) $display("FAIL busy_ignore_latency: got %0d expected 10", n); else passes++;
    checks++; if (LO !== 32'd14) $display("FAIL busy_ignore_lo: got %h expected 0000000e", LO); else passes++;
    checks++; if (HI !== 32'd2) $display("FAIL busy_ignore_hi: got %h expected 00000002", HI); else passes++;
    // Issue in the first cycle busy is low: no dead cycle.
    do_start(3'd0, 32'd7, 32'd6);
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %0b expected 1", busy); else passes++;
    wait_idle(n);
    checks++; if (n !== 5) $display("FAIL b2b_latency: got %0d expected 5", n); else passes++;
    checks++; if (LO !== 32'd42) $display("FAIL b2b_lo: got %h expected 0000002a", LO); else passes++;
    checks++; if (HI !== 32'd0) $display("FAIL b2b_hi: got %h expected 00000000", HI); else passes++;
  endtask

  task automatic test_madd();
    int n;
    do_mt(1'b1, 32'h0);
    do_mt(1'b0, 32'hFFFFFFFF);
    do_start(3'd5, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(n);
    checks++; if (n !== 5) $display("FAIL maddu_latency: got %0d expected 5", n); else passes++;
    checks++; if (HI !== 32'h1) $display("FAIL maddu_hi: got %h expected 00000001", HI); else passes++;
    checks++; if (LO !== 32'h0) $display("FAIL maddu_lo: got %h expected 00000000", LO); else passes++;
    do_start(3'd6, 32'hFFFFFFFF, 32'd1);
    wait_idle(n);
    checks++; if (HI !== 32'h1) $display("FAIL msub_hi: got %h expected 00000001", HI); else passes++;
    checks++; if (LO !== 32'h1) $display("FAIL msub_lo: got %h expected 00000001", LO); else passes++;
`else
    checks++; if (busy !== 1'b0) $display("FAIL maddu_off_busy: got %0b expected 0", busy); else passes++;
    wait_idle(n);
    checks++; if (HI !== 32'h0) $display("FAIL maddu_off_hi: got %h expected 00000000", HI); else passes++;
    checks++; if (LO !== 32'hFFFFFFFF) $display("FAIL maddu_off_lo: got %h expected ffffffff", LO); else passes++;
`endif
  endtask

  task automatic test_reset_abort();
    int n;
    do_mt(1'b1, 32'hA5A5A5A5);
    do_start(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy); else passes++;
    checks++; if (HI !== 32'h0) $display("FAIL abort_hi: got %h expected 00000000", HI); else passes++;
    checks++; if (LO !== 32'h0) $display("FAIL abort_lo: got %h expected 00000000", LO); else passes++;
    repeat (12) @(negedge clk);
    wait_idle(n);
    checks++; if (n !== 0) $display("FAIL abort_no_run: got %0d expected 0", n); else passes++;
    checks++; if (LO !== 32'h0) $display("FAIL abort_no_commit_lo: got %h expected 00000000", LO); else passes++;
    checks++; if (HI !== 32'h0) $display("FAIL abort_no_commit_hi: got %h expected 00000000", HI); else passes++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_hilo();
    test_back_to_back();
    test_madd();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
